// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment driver.
package seg_pkg;

  // Converter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  // Active-low segment patterns, bit order g..a (bit 6 = g, bit 0 = a).
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Position of the decimal point inside the 8-bit cathode bus.
  localparam int SEG_DP_BIT = 7;

  // BCD digit to active-low segment pattern; non-decimal codes go dark.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle).
//
// Handshake: load_i is a single-cycle request that is accepted only in
// ST_IDLE; there is no ready/queue, so a request in ST_SHIFT or ST_COMMIT is
// dropped. done_o is high for exactly the one ST_COMMIT cycle, during which
// bcd_o/overflow_o hold the finished result for the consumer to capture.
module seg_bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int N_DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     value_i,
  input  logic                  load_i,
  output logic [4*N_DIGITS-1:0] bcd_o,
  output logic                  overflow_o,
  output logic                  done_o,
  output conv_state_t           state_o
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  conv_state_t       state_q;
  conv_state_t       state_d;
  logic [DATA_W-1:0] bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  bcd_adj;
  logic              ovf_q;
  logic [CNT_W-1:0]  cnt_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE -> SHIFT on load, SHIFT for DATA_W steps, one COMMIT cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (load_i) state_d = ST_SHIFT;
      ST_SHIFT:  if (cnt_q == CNT_LAST) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Add-3 correction for every BCD digit that is 5 or more before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Datapath: capture on accept, then shift MSB-first into the BCD register.
  // A 1 leaving the top digit means the value needs more digits than we
  // have, so it is folded into a sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_i) begin
            bin_q <= value_i;
            bcd_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
          end
        end
        ST_SHIFT: begin
          bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
          bin_q <= {bin_q[DATA_W-2:0], 1'b0};
          ovf_q <= ovf_q | bcd_adj[BCD_W-1];
          cnt_q <= cnt_q + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign bcd_o      = bcd_q;
  assign overflow_o = ovf_q;
  assign done_o     = (state_q == ST_COMMIT);
  assign state_o    = state_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment driver: converts a binary value to decimal and
// scans it across N_DIGITS common-anode digits with active-low drive.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int N_DIGITS    = 5,
  parameter int REFRESH_DIV = 36864,
  parameter int BLANK_LZ    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   value_i,
  input  logic                load_i,
  input  logic [N_DIGITS-1:0] dp_i,
  output logic                busy_o,
  output logic                overflow_o,
  output logic [N_DIGITS-1:0] anode_o,
  output logic [7:0]          cathode_o
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int RC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [BCD_W-1:0]    conv_bcd;
  logic                conv_ovf;
  logic                conv_done;
  conv_state_t         conv_state;

  logic [BCD_W-1:0]    disp_bcd;
  logic                disp_ovf;
  logic [RC_W-1:0]     refresh_cnt;
  logic [IDX_W-1:0]    digit_idx;

  logic [3:0]          cur_digit;
  logic                upper_zero;
  logic                dp_next;
  logic [6:0]          seg_next;
  logic [N_DIGITS-1:0] anode_next;

  seg_bin2bcd_seq #(
    .DATA_W   (DATA_W),
    .N_DIGITS (N_DIGITS)
  ) u_conv (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_i    (value_i),
    .load_i     (load_i),
    .bcd_o      (conv_bcd),
    .overflow_o (conv_ovf),
    .done_o     (conv_done),
    .state_o    (conv_state)
  );

  // busy covers exactly the shift phase; the commit cycle already reads as idle.
  assign busy_o = (conv_state == ST_SHIFT);

  // Display register: digits and overflow flag are replaced together on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_bcd <= '0;
      disp_ovf <= 1'b0;
    end else if (conv_done) begin
      disp_bcd <= conv_bcd;
      disp_ovf <= conv_ovf;
    end
  end

  assign overflow_o = disp_ovf;

  // Refresh divider and digit index; the index steps once per divider wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == RC_LAST) begin
      refresh_cnt <= '0;
      digit_idx   <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      refresh_cnt <= refresh_cnt + RC_W'(1);
    end
  end

  // Select the active digit, its dp bit, and whether it and everything above is zero.
  always_comb begin
    cur_digit  = 4'd0;
    dp_next    = 1'b0;
    upper_zero = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (digit_idx == IDX_W'(k)) begin
        cur_digit = disp_bcd[4*k +: 4];
        dp_next   = dp_i[k];
      end
      if ((IDX_W'(k) >= digit_idx) && (disp_bcd[4*k +: 4] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
  end

  // Segment pattern: overflow dash wins, then leading-zero blank, then the digit.
  always_comb begin
    seg_next = seg_encode(cur_digit);
    if (disp_ovf) begin
      seg_next = SEG_DASH;
    end else if ((BLANK_LZ != 0) && (digit_idx != '0) && upper_zero) begin
      seg_next = SEG_BLANK;
    end
    anode_next = ~(N_DIGITS'(1) << digit_idx);
  end

  // Registered pin drivers so no input reaches the pins combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_o   <= '1;
      cathode_o <= 8'hFF;
    end else begin
      anode_o                <= anode_next;
      cathode_o[SEG_DP_BIT]  <= ~dp_next;
      cathode_o[6:0]         <= seg_next;
    end
  end

endmodule
